// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: walks one active-low row at a time, debounces the
// press and the release, strobes each confirmed key and shifts it into data.
module keypad_scan #(
  parameter int SCAN_DIV = 2000,
  parameter int DEBOUNCE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [31:0] data
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    col_s1_q, cs_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [BW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_pressed_q, key_pressed_d;
  logic [31:0]   data_q, data_d;

  logic          tick;
  logic          col_hi;
  logic          commit;
  logic [3:0]    map_code;

  // Keypad legend: rows top to bottom, columns left to right; '*'=E, '#'=F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  assign col_hi    = cs_q[col_idx_q];
  assign map_code  = key_map(row_idx_q, col_idx_q);

  // State register plus datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_SCAN;
      col_s1_q      <= 4'hF;
      cs_q          <= 4'hF;
      div_cnt_q     <= '0;
      row_idx_q     <= 2'd0;
      col_idx_q     <= 2'd0;
      db_cnt_q      <= '0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      data_q        <= 32'h0;
    end else begin
      state_q       <= state_d;
      col_s1_q      <= col;
      cs_q          <= col_s1_q;
      div_cnt_q     <= div_cnt_d;
      row_idx_q     <= row_idx_d;
      col_idx_q     <= col_idx_d;
      db_cnt_q      <= db_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      data_q        <= data_d;
    end
  end

  // Next-state: only tick cycles move the FSM; the row stays put while a key is tracked.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    db_cnt_d  = db_cnt_q;
    commit    = 1'b0;
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (cs_q == 4'hF) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            col_idx_d = first_low(cs_q);
            db_cnt_d  = '0;
            state_d   = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (col_hi) begin
            state_d   = S_SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end else if (db_cnt_q == DB_LAST) begin
            commit  = 1'b1;
            state_d = S_HELD;
          end else begin
            db_cnt_d = db_cnt_q + BW'(1);
          end
        end
        S_HELD: begin
          if (col_hi) begin
            state_d  = S_RELEASE;
            db_cnt_d = '0;
          end
        end
        default: begin
          if (!col_hi) begin
            state_d = S_HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_d   = S_SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            db_cnt_d = db_cnt_q + BW'(1);
          end
        end
      endcase
    end
  end

  // Outputs: clear beats a simultaneous commit for data only.
  always_comb begin
    key_code_d    = commit ? map_code : key_code_q;
    key_valid_d   = commit;
    key_pressed_d = (state_d == S_HELD) || (state_d == S_RELEASE);
    if (clear)       data_d = 32'h0;
    else if (commit) data_d = {data_q[27:0], map_code};
    else             data_d = data_q;
  end

  assign row         = ~(4'b0001 << row_idx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;
  assign data        = data_q;

endmodule
